// File: rtl/cal_pkg.sv
// Shared types and BCD helper functions for the calendar clock.
// All arithmetic is digit-wise on BCD; nothing is converted to binary.
package cal_pkg;

    typedef enum logic [2:0] {
        SEC   = 3'd0,
        MIN   = 3'd1,
        HOUR  = 3'd2,
        DAY   = 3'd3,
        MONTH = 3'd4,
        YEAR  = 3'd5
    } field_e;

    typedef logic [3:0] bcd_digit_t;

    // Any value at or above hi wraps to lo, which also repairs an out-of-range day.
    function automatic logic [7:0] bcd2_inc_wrap(input logic [7:0] val, input logic [7:0] lo,
                                                 input logic [7:0] hi);
        bcd_digit_t tens;
        bcd_digit_t ones;
        tens = val[7:4];
        ones = val[3:0];
        if (val >= hi) return lo;
        if (ones == 4'd9) return {tens + 4'd1, 4'd0};
        return {tens, ones + 4'd1};
    endfunction

    function automatic logic [7:0] bcd2_dec_wrap(input logic [7:0] val, input logic [7:0] lo,
                                                 input logic [7:0] hi);
        bcd_digit_t tens;
        bcd_digit_t ones;
        tens = val[7:4];
        ones = val[3:0];
        if (val <= lo || val > hi) return hi;
        if (ones == 4'd0) return {tens - 4'd1, 4'd9};
        return {tens, ones - 4'd1};
    endfunction

    function automatic logic [15:0] bcd4_inc(input logic [15:0] val);
        logic [7:0] hi_byte;
        hi_byte = (val[7:0] == 8'h99) ? bcd2_inc_wrap(val[15:8], 8'h00, 8'h99) : val[15:8];
        return {hi_byte, bcd2_inc_wrap(val[7:0], 8'h00, 8'h99)};
    endfunction

    function automatic logic [15:0] bcd4_dec(input logic [15:0] val);
        logic [7:0] hi_byte;
        hi_byte = (val[7:0] == 8'h00) ? bcd2_dec_wrap(val[15:8], 8'h00, 8'h99) : val[15:8];
        return {hi_byte, bcd2_dec_wrap(val[7:0], 8'h00, 8'h99)};
    endfunction

    function automatic logic bcd2_div4(input logic [7:0] val);
        bcd_digit_t ones;
        ones = val[3:0];
        if (!val[4]) return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
        return (ones == 4'd2) || (ones == 4'd6);
    endfunction

    function automatic logic is_leap(input logic [15:0] yyyy);
        if (yyyy[7:0] != 8'h00) return bcd2_div4(yyyy[7:0]);
        return bcd2_div4(yyyy[15:8]);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] mo, input logic leap);
        case (mo)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return leap ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] hour_to_12(input logic [7:0] hh);
        if (hh == 8'h00) return 8'h12;
        if (hh <= 8'h12) return hh;
        if (hh[7:4] == 4'd1) return {4'd0, hh[3:0] - 4'd2};
        if (hh[3:0] < 4'd2) return {4'd0, hh[3:0] + 4'd8};
        return {4'd1, hh[3:0] - 4'd2};
    endfunction

    function automatic field_e next_field(input field_e f);
        case (f)
            SEC:     return MIN;
            MIN:     return HOUR;
            HOUR:    return DAY;
            DAY:     return MONTH;
            MONTH:   return YEAR;
            default: return SEC;
        endcase
    endfunction

endpackage

// File: rtl/cal_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; hold parks it at zero.
module cal_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] count;

    assign tick = (count == LAST) && !hold;

    always_ff @(posedge clk) begin
        if (rst || hold || tick) begin
            count <= '0;
        end else begin
            count <= count + TICK_W'(1);
        end
    end

endmodule

// File: rtl/bcd_calendar_clock.sv
// BCD time-of-day and Gregorian calendar with button-driven field editing
// and an optional 12-hour display view.
module bcd_calendar_clock
    import cal_pkg::*;
#(
    parameter int          TICK_DIV  = 50_000_000,
    parameter logic [15:0] RST_YEAR  = 16'h2024,
    parameter logic [7:0]  RST_MONTH = 8'h01,
    parameter logic [7:0]  RST_DAY   = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        edit_en,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        mode_12h,
    output logic [23:0] time_bcd,
    output logic [31:0] date_bcd,
    output logic [7:0]  hour_disp,
    output logic        pm,
    output logic [2:0]  sel_field,
    output logic        tick_1hz
);

    logic [7:0]  ss, mm, hh, dd, mo;
    logic [15:0] yyyy;
    field_e      sel_q;
    logic        sel_prev, inc_prev, dec_prev;
    logic        sel_pulse, inc_pulse, dec_pulse;
    logic        tick;
    logic [7:0]  dim;

    cal_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .hold (edit_en),
        .tick (tick)
    );

    assign sel_pulse = btn_sel & ~sel_prev;
    assign inc_pulse = btn_inc & ~inc_prev;
    assign dec_pulse = btn_dec & ~dec_prev;
    assign dim       = days_in_month(mo, is_leap(yyyy));

    always_ff @(posedge clk) begin
        if (rst) begin
            ss       <= 8'h00;
            mm       <= 8'h00;
            hh       <= 8'h00;
            dd       <= RST_DAY;
            mo       <= RST_MONTH;
            yyyy     <= RST_YEAR;
            sel_q    <= SEC;
            sel_prev <= 1'b1;
            inc_prev <= 1'b1;
            dec_prev <= 1'b1;
        end else begin
            sel_prev <= btn_sel;
            inc_prev <= btn_inc;
            dec_prev <= btn_dec;
            // Clamp runs first so any same-cycle write to dd below takes precedence.
            if (dd > dim) dd <= dim;
            if (edit_en) begin
                if (sel_pulse) begin
                    sel_q <= next_field(sel_q);
                end else if (inc_pulse ^ dec_pulse) begin
                    case (sel_q)
                        SEC:   ss <= inc_pulse ? bcd2_inc_wrap(ss, 8'h00, 8'h59)
                                               : bcd2_dec_wrap(ss, 8'h00, 8'h59);
                        MIN:   mm <= inc_pulse ? bcd2_inc_wrap(mm, 8'h00, 8'h59)
                                               : bcd2_dec_wrap(mm, 8'h00, 8'h59);
                        HOUR:  hh <= inc_pulse ? bcd2_inc_wrap(hh, 8'h00, 8'h23)
                                               : bcd2_dec_wrap(hh, 8'h00, 8'h23);
                        DAY:   dd <= inc_pulse ? bcd2_inc_wrap(dd, 8'h01, dim)
                                               : bcd2_dec_wrap(dd, 8'h01, dim);
                        MONTH: mo <= inc_pulse ? bcd2_inc_wrap(mo, 8'h01, 8'h12)
                                               : bcd2_dec_wrap(mo, 8'h01, 8'h12);
                        YEAR:  yyyy <= inc_pulse ? bcd4_inc(yyyy) : bcd4_dec(yyyy);
                        default: ;
                    endcase
                end
            end else if (tick) begin
                ss <= bcd2_inc_wrap(ss, 8'h00, 8'h59);
                if (ss == 8'h59) begin
                    mm <= bcd2_inc_wrap(mm, 8'h00, 8'h59);
                    if (mm == 8'h59) begin
                        hh <= bcd2_inc_wrap(hh, 8'h00, 8'h23);
                        if (hh == 8'h23) begin
                            dd <= bcd2_inc_wrap(dd, 8'h01, dim);
                            if (dd >= dim) begin
                                mo <= bcd2_inc_wrap(mo, 8'h01, 8'h12);
                                if (mo == 8'h12) yyyy <= bcd4_inc(yyyy);
                            end
                        end
                    end
                end
            end
        end
    end

    assign time_bcd  = {hh, mm, ss};
    assign date_bcd  = {dd, mo, yyyy};
    assign hour_disp = mode_12h ? hour_to_12(hh) : hh;
    assign pm        = (hh >= 8'h12);
    assign sel_field = sel_q;
    assign tick_1hz  = tick;

endmodule

// File: tb/tb_bcd_calendar_clock.sv
// Scenario bench for bcd_calendar_clock with a fast prescaler and a queue of
// expected {time,date} snapshots consumed after each observed tick.
module tb_bcd_calendar_clock;

    localparam int TD = 4;

    localparam logic [15:0] LEAP_YR   [3] = '{16'h2024, 16'h2000, 16'h2023};
    localparam logic [31:0] LEAP_DATE [3] = '{{8'h29, 8'h02, 16'h2024},
                                              {8'h29, 8'h02, 16'h2000},
                                              {8'h01, 8'h03, 16'h2023}};
    localparam logic [7:0]  HH_IN  [4] = '{8'h13, 8'h12, 8'h23, 8'h09};
    localparam logic [7:0]  HH_12  [4] = '{8'h01, 8'h12, 8'h11, 8'h09};
    localparam logic        HH_PM  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        edit_en = 1'b0;
    logic        btn_sel = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic        mode_12h = 1'b0;
    logic [23:0] time_bcd;
    logic [31:0] date_bcd;
    logic [7:0]  hour_disp;
    logic        pm;
    logic [2:0]  sel_field;
    logic        tick_1hz;

    int total = 0;
    int bad = 0;
    logic [55:0] exp_q[$];
    logic [55:0] exp_v;

    always #5 clk = ~clk;

    bcd_calendar_clock #(
        .TICK_DIV  (TD),
        .RST_YEAR  (16'h2024),
        .RST_MONTH (8'h01),
        .RST_DAY   (8'h01)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .edit_en   (edit_en),
        .btn_sel   (btn_sel),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .mode_12h  (mode_12h),
        .time_bcd  (time_bcd),
        .date_bcd  (date_bcd),
        .hour_disp (hour_disp),
        .pm        (pm),
        .sel_field (sel_field),
        .tick_1hz  (tick_1hz)
    );

    function automatic logic [15:0] get_field(input int f);
        case (f)
            0:       return {8'h00, time_bcd[7:0]};
            1:       return {8'h00, time_bcd[15:8]};
            2:       return {8'h00, time_bcd[23:16]};
            3:       return {8'h00, date_bcd[31:24]};
            4:       return {8'h00, date_bcd[23:16]};
            default: return date_bcd[15:0];
        endcase
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    endfunction

    task automatic press(input logic s, input logic i, input logic d);
        btn_sel = s; btn_inc = i; btn_dec = d;
        @(negedge clk);
        btn_sel = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        @(negedge clk);
    endtask

    task automatic select(input int f);
        for (int n = 0; n < 6 && sel_field != 3'(f); n++) press(1'b1, 1'b0, 1'b0);
        total++;
        if (sel_field !== 3'(f)) begin
            bad++;
            $display("FAIL select got=%0d want=%0d", sel_field, f);
        end
    endtask

    task automatic set_field(input int f, input logic [15:0] tgt);
        int fwd;
        select(f);
        if (f == 5) begin
            fwd = (bcd2int(tgt) - bcd2int(get_field(5)) + 10000) % 10000;
            if (fwd <= 5000) repeat (fwd) press(1'b0, 1'b1, 1'b0);
            else repeat (10000 - fwd) press(1'b0, 1'b0, 1'b1);
        end else begin
            for (int n = 0; n < 100 && get_field(f) != tgt; n++) press(1'b0, 1'b1, 1'b0);
        end
        total++;
        if (get_field(f) !== tgt) begin
            bad++;
            $display("FAIL set_field%0d got=%h want=%h", f, get_field(f), tgt);
        end
    endtask

    task automatic set_dt(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic [7:0] d, input logic [7:0] mo, input logic [15:0] y);
        edit_en = 1'b1;
        @(negedge clk);
        set_field(5, y);
        set_field(4, {8'h00, mo});
        set_field(3, {8'h00, d});
        set_field(2, {8'h00, h});
        set_field(1, {8'h00, m});
        set_field(0, {8'h00, s});
    endtask

    // Leaves edit mode and stops on the negedge just after the first tick edge.
    task automatic run_tick();
        edit_en = 1'b0;
        for (int n = 0; n < 3 * TD && !tick_1hz; n++) @(negedge clk);
        if (!tick_1hz) begin
            total++;
            bad++;
            $display("FAIL tick_timeout got=0 want=1");
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        edit_en = 1'b1; btn_inc = 1'b1; mode_12h = 1'b1; rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({time_bcd, date_bcd} !== {24'h000000, 8'h01, 8'h01, 16'h2024}) begin
            bad++;
            $display("FAIL reset_values got=%h want=%h", {time_bcd, date_bcd},
                     {24'h000000, 8'h01, 8'h01, 16'h2024});
        end
        total++;
        if ({sel_field, tick_1hz, pm, hour_disp} !== {3'd0, 1'b0, 1'b0, 8'h12}) begin
            bad++;
            $display("FAIL reset_ctrl got=%h want=%h", {sel_field, tick_1hz, pm, hour_disp},
                     {3'd0, 1'b0, 1'b0, 8'h12});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (time_bcd !== 24'h000000) begin
            bad++;
            $display("FAIL held_button got=%h want=000000", time_bcd);
        end
        btn_inc = 1'b0; mode_12h = 1'b0;
        #1;
        total++;
        if (hour_disp !== 8'h00) begin
            bad++;
            $display("FAIL reset_hour24 got=%h want=00", hour_disp);
        end
        @(negedge clk);
        edit_en = 1'b0;
        exp_q.push_back({24'h000001, 32'h0});
        exp_q.push_back({24'h000002, 32'h0});
        for (int k = 0; k < 12; k++) begin
            total++;
            if (tick_1hz !== (k % 4 == 3)) begin
                bad++;
                $display("FAIL tick_period k=%0d got=%b want=%b", k, tick_1hz, (k % 4 == 3));
            end
            if (k == 4 || k == 8) begin
                exp_v = exp_q.pop_front();
                total++;
                if (time_bcd !== exp_v[55:32]) begin
                    bad++;
                    $display("FAIL first_ticks k=%0d got=%h want=%h", k, time_bcd, exp_v[55:32]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_century();
        set_dt(8'h23, 8'h59, 8'h59, 8'h31, 8'h12, 16'h2099);
        exp_q.push_back({24'h000000, 8'h01, 8'h01, 16'h2100});
        run_tick();
        exp_v = exp_q.pop_front();
        total++;
        if ({time_bcd, date_bcd} !== exp_v) begin
            bad++;
            $display("FAIL century_roll got=%h want=%h", {time_bcd, date_bcd}, exp_v);
        end
        set_dt(8'h23, 8'h59, 8'h59, 8'h28, 8'h02, 16'h2100);
        exp_q.push_back({24'h000000, 8'h01, 8'h03, 16'h2100});
        run_tick();
        exp_v = exp_q.pop_front();
        total++;
        if ({time_bcd, date_bcd} !== exp_v) begin
            bad++;
            $display("FAIL feb_2100 got=%h want=%h", {time_bcd, date_bcd}, exp_v);
        end
    endtask

    task automatic test_leap();
        for (int i = 0; i < 3; i++) begin
            set_dt(8'h23, 8'h59, 8'h59, 8'h28, 8'h02, LEAP_YR[i]);
            exp_q.push_back({24'h000000, LEAP_DATE[i]});
            run_tick();
            exp_v = exp_q.pop_front();
            total++;
            if ({time_bcd, date_bcd} !== exp_v) begin
                bad++;
                $display("FAIL leap_%h got=%h want=%h", LEAP_YR[i], {time_bcd, date_bcd}, exp_v);
            end
        end
        set_dt(8'h23, 8'h59, 8'h59, 8'h29, 8'h02, 16'h2024);
        exp_q.push_back({24'h000000, 8'h01, 8'h03, 16'h2024});
        run_tick();
        exp_v = exp_q.pop_front();
        total++;
        if ({time_bcd, date_bcd} !== exp_v) begin
            bad++;
            $display("FAIL leap_end got=%h want=%h", {time_bcd, date_bcd}, exp_v);
        end
    endtask

    task automatic test_clamp();
        set_dt(8'h10, 8'h00, 8'h00, 8'h31, 8'h01, 16'h2024);
        select(4);
        btn_inc = 1'b1;
        @(negedge clk);
        total++;
        if (date_bcd[31:16] !== {8'h31, 8'h02}) begin
            bad++;
            $display("FAIL month_edit got=%h want=3102", date_bcd[31:16]);
        end
        btn_inc = 1'b0;
        @(negedge clk);
        total++;
        if (date_bcd[31:24] !== 8'h29) begin
            bad++;
            $display("FAIL clamp_feb_leap got=%h want=29", date_bcd[31:24]);
        end
        select(5);
        btn_inc = 1'b1;
        @(negedge clk);
        btn_inc = 1'b0;
        @(negedge clk);
        total++;
        if (date_bcd !== {8'h28, 8'h02, 16'h2025}) begin
            bad++;
            $display("FAIL clamp_year got=%h want=28022025", date_bcd);
        end
    endtask

    task automatic test_edit();
        set_dt(8'h12, 8'h34, 8'h00, 8'h15, 8'h06, 16'h2025);
        select(0);
        press(1'b0, 1'b0, 1'b1);
        total++;
        if (time_bcd !== 24'h123459) begin
            bad++;
            $display("FAIL dec_wrap got=%h want=123459", time_bcd);
        end
        press(1'b0, 1'b1, 1'b1);
        total++;
        if (time_bcd !== 24'h123459) begin
            bad++;
            $display("FAIL inc_and_dec got=%h want=123459", time_bcd);
        end
        press(1'b1, 1'b1, 1'b0);
        total++;
        if ({sel_field, time_bcd} !== {3'd1, 24'h123459}) begin
            bad++;
            $display("FAIL sel_priority got=%h want=%h", {sel_field, time_bcd}, {3'd1, 24'h123459});
        end
        for (int k = 0; k < 10 * TD; k++) begin
            @(negedge clk);
            if (tick_1hz) begin
                total++;
                bad++;
                $display("FAIL tick_in_edit k=%0d got=1 want=0", k);
            end
        end
        total++;
        if (time_bcd !== 24'h123459) begin
            bad++;
            $display("FAIL edit_frozen got=%h want=123459", time_bcd);
        end
        edit_en = 1'b0;
        press(1'b1, 1'b1, 1'b1);
        total++;
        if (sel_field !== 3'd1) begin
            bad++;
            $display("FAIL run_mode_sel got=%0d want=1", sel_field);
        end
    endtask

    task automatic test_wrap_12h();
        set_dt(8'h23, 8'h59, 8'h59, 8'h31, 8'h12, 16'h9999);
        exp_q.push_back({24'h000000, 8'h01, 8'h01, 16'h0000});
        run_tick();
        exp_v = exp_q.pop_front();
        total++;
        if ({time_bcd, date_bcd} !== exp_v) begin
            bad++;
            $display("FAIL year_wrap got=%h want=%h", {time_bcd, date_bcd}, exp_v);
        end
        mode_12h = 1'b1;
        #1;
        total++;
        if ({hour_disp, pm} !== {8'h12, 1'b0}) begin
            bad++;
            $display("FAIL h12_midnight got=%h want=%h", {hour_disp, pm}, {8'h12, 1'b0});
        end
        @(negedge clk);
        edit_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            set_field(2, {8'h00, HH_IN[i]});
            total++;
            if ({hour_disp, pm} !== {HH_12[i], HH_PM[i]}) begin
                bad++;
                $display("FAIL h12_%h got=%h want=%h", HH_IN[i], {hour_disp, pm}, {HH_12[i], HH_PM[i]});
            end
        end
        set_field(2, 16'h0023);
        mode_12h = 1'b0;
        #1;
        total++;
        if ({hour_disp, pm} !== {8'h23, 1'b1}) begin
            bad++;
            $display("FAIL h24_view got=%h want=%h", {hour_disp, pm}, {8'h23, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_century();
        test_leap();
        test_clamp();
        test_edit();
        test_wrap_12h();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
